// File: rtl/btn_evt_arbiter.sv
// Per-channel button event generator with a round-robin arbiter.
// Each channel runs an IDLE/PRESS/HOLD FSM. Events go into a one-deep
// pending slot per channel, and one output register is fed from those slots.
// Optional feature: define BTN_AUTO_REPEAT_EN to re-emit HOLD every
// REPEAT_CYC edges while a button stays held.
//
// Handshake: an event transfers on a rising edge where o_evt_valid and
// i_evt_ready are both high. While o_evt_valid=1 and i_evt_ready=0,
// o_evt_id and o_evt_kind hold. While o_evt_valid=0 both read 0.

package my_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PRESS = 2'b01,
        HOLD  = 2'b10
    } state_e;
endpackage

module btn_evt_arbiter
    import my_pkg::*;
#(
    parameter int NUM_BTN    = 4,
    parameter int HOLD_CYC   = 8,
    parameter int REPEAT_CYC = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NUM_BTN-1:0]         i_btn,
    output logic                       o_evt_valid,
    input  logic                       i_evt_ready,
    output logic [$clog2(NUM_BTN)-1:0] o_evt_id,
    output logic [1:0]                 o_evt_kind,
    output logic [2*NUM_BTN-1:0]       o_state,
    output logic                       o_drop
);

    localparam int ID_W  = $clog2(NUM_BTN);
    localparam int CNT_W = $clog2(HOLD_CYC);

    if (NUM_BTN < 2 || NUM_BTN > 8 || HOLD_CYC < 2 || REPEAT_CYC < 1) begin : g_bad_param
        $error("btn_evt_arbiter: parameter out of range");
    end

    state_e             state_q [NUM_BTN];
    state_e             state_d [NUM_BTN];
    logic [CNT_W-1:0]   cnt_q   [NUM_BTN];
    logic [CNT_W-1:0]   cnt_d   [NUM_BTN];
    logic [NUM_BTN-1:0] raise;
    state_e             raise_kind [NUM_BTN];

`ifdef BTN_AUTO_REPEAT_EN
    localparam int REP_W = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
    logic [REP_W-1:0]   rep_q [NUM_BTN];
    logic [REP_W-1:0]   rep_d [NUM_BTN];
`endif

    logic [NUM_BTN-1:0] pend_v_q;
    state_e             pend_k_q [NUM_BTN];

    logic               out_v_q;
    logic [ID_W-1:0]    out_id_q;
    state_e             out_k_q;
    logic [ID_W-1:0]    ptr_q;
    logic               drop_q;

    logic               load;
    logic               gnt_any;
    logic [ID_W-1:0]    gnt_idx;
    logic [NUM_BTN-1:0] grant;
    state_e             gnt_kind;
    logic [ID_W-1:0]    ptr_next;

    // Per-channel next state, hold counter and event raise.
    always_comb begin
        for (int n = 0; n < NUM_BTN; n++) begin
            state_d[n]    = state_q[n];
            cnt_d[n]      = cnt_q[n];
            raise[n]      = 1'b0;
            raise_kind[n] = IDLE;
`ifdef BTN_AUTO_REPEAT_EN
            rep_d[n]      = rep_q[n];
`endif
            case (state_q[n])
                IDLE: begin
                    if (i_btn[n]) begin
                        state_d[n]    = PRESS;
                        cnt_d[n]      = '0;
                        raise[n]      = 1'b1;
                        raise_kind[n] = PRESS;
                    end
                end
                PRESS: begin
                    if (!i_btn[n]) begin
                        state_d[n]    = IDLE;
                        raise[n]      = 1'b1;
                        raise_kind[n] = IDLE;
                    end else if (cnt_q[n] == CNT_W'(HOLD_CYC - 1)) begin
                        state_d[n]    = HOLD;
                        raise[n]      = 1'b1;
                        raise_kind[n] = HOLD;
`ifdef BTN_AUTO_REPEAT_EN
                        rep_d[n]      = '0;
`endif
                    end else begin
                        cnt_d[n] = cnt_q[n] + 1'b1;
                    end
                end
                HOLD: begin
                    if (!i_btn[n]) begin
                        state_d[n]    = IDLE;
                        raise[n]      = 1'b1;
                        raise_kind[n] = IDLE;
                    end
`ifdef BTN_AUTO_REPEAT_EN
                    else if (rep_q[n] == REP_W'(REPEAT_CYC - 1)) begin
                        raise[n]      = 1'b1;
                        raise_kind[n] = HOLD;
                        rep_d[n]      = '0;
                    end else begin
                        rep_d[n] = rep_q[n] + 1'b1;
                    end
`endif
                end
                // 2'b11 is not a legal state: fall back to IDLE silently.
                default: state_d[n] = IDLE;
            endcase
        end
    end

    // Channel FSM state and counters.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int n = 0; n < NUM_BTN; n++) begin
                state_q[n] <= IDLE;
                cnt_q[n]   <= '0;
`ifdef BTN_AUTO_REPEAT_EN
                rep_q[n]   <= '0;
`endif
            end
        end else begin
            for (int n = 0; n < NUM_BTN; n++) begin
                state_q[n] <= state_d[n];
                cnt_q[n]   <= cnt_d[n];
`ifdef BTN_AUTO_REPEAT_EN
                rep_q[n]   <= rep_d[n];
`endif
            end
        end
    end

    // Round-robin pick of the first pending channel at or after ptr_q.
    always_comb begin
        int c;
        c        = 0;
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        grant    = '0;
        load     = !out_v_q || i_evt_ready;
        for (int i = 0; i < NUM_BTN; i++) begin
            c = int'(ptr_q) + i;
            if (c >= NUM_BTN) c = c - NUM_BTN;
            if (!gnt_any && pend_v_q[c]) begin
                gnt_any = 1'b1;
                gnt_idx = ID_W'(c);
            end
        end
        if (load && gnt_any) grant[gnt_idx] = 1'b1;
        gnt_kind = pend_k_q[gnt_idx];
        ptr_next = (int'(gnt_idx) == NUM_BTN - 1) ? '0 : gnt_idx + 1'b1;
    end

    // Pending slots: a new event always wins, even over a same-edge grant.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pend_v_q <= '0;
            drop_q   <= 1'b0;
            for (int n = 0; n < NUM_BTN; n++) pend_k_q[n] <= IDLE;
        end else begin
            drop_q <= |(raise & pend_v_q & ~grant);
            for (int n = 0; n < NUM_BTN; n++) begin
                if (raise[n]) begin
                    pend_v_q[n] <= 1'b1;
                    pend_k_q[n] <= raise_kind[n];
                end else if (grant[n]) begin
                    pend_v_q[n] <= 1'b0;
                end
            end
        end
    end

    // Output register, reloaded when empty or when the consumer takes it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_v_q  <= 1'b0;
            out_id_q <= '0;
            out_k_q  <= IDLE;
            ptr_q    <= '0;
        end else if (load) begin
            out_v_q  <= gnt_any;
            out_id_q <= gnt_any ? gnt_idx : '0;
            out_k_q  <= gnt_any ? gnt_kind : IDLE;
            if (gnt_any) ptr_q <= ptr_next;
        end
    end

    // Flatten channel states for observation.
    always_comb begin
        o_state = '0;
        for (int n = 0; n < NUM_BTN; n++) o_state[2*n +: 2] = state_q[n];
    end

    assign o_evt_valid = out_v_q;
    assign o_evt_id    = out_id_q;
    assign o_evt_kind  = out_k_q;
    assign o_drop      = drop_q;

endmodule

// File: tb/tb_btn_evt_arbiter.sv
// Self-checking bench for btn_evt_arbiter: expected events are queued as
// stimulus is applied and compared against accepted output events.
module tb_btn_evt_arbiter;
  import my_pkg::*;

  localparam int NUM_BTN    = 4;
  localparam int HOLD_CYC   = 8;
  localparam int REPEAT_CYC = 4;
  localparam int IDW        = $clog2(NUM_BTN);
  localparam int W          = IDW + 2;

  logic               i_clk;
  logic               i_rst;
  logic [NUM_BTN-1:0] i_btn;
  logic               o_evt_valid;
  logic               i_evt_ready;
  logic [IDW-1:0]     o_evt_id;
  logic [1:0]         o_evt_kind;
  logic [2*NUM_BTN-1:0] o_state;
  logic               o_drop;

  btn_evt_arbiter #(
    .NUM_BTN(NUM_BTN), .HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_btn(i_btn),
    .o_evt_valid(o_evt_valid), .i_evt_ready(i_evt_ready),
    .o_evt_id(o_evt_id), .o_evt_kind(o_evt_kind),
    .o_state(o_state), .o_drop(o_drop)
  );

  // clock / reset block
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int           obs_cyc_q[$];
  int           drop_cnt = 0;
  int           n_cmp = 0;
  int           n_fail = 0;

  // Record each accepted event (transfer happens at the next rising edge).
  always @(negedge i_clk) begin
    if (!i_rst && o_evt_valid && i_evt_ready) begin
      obs_q.push_back({o_evt_kind, o_evt_id});
      obs_cyc_q.push_back(cyc);
    end
    if (o_drop) drop_cnt++;
  end

  function automatic logic [W-1:0] mk(input logic [1:0] k, input int id);
    return {k, IDW'(id)};
  endfunction

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset;
    i_rst = 1'b1; i_btn = '0; i_evt_ready = 1'b0;
    #3;
    n_cmp++;
    if (o_evt_valid !== 1'b0 || o_evt_id !== '0 || o_evt_kind !== 2'b00 ||
        o_state !== '0 || o_drop !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%b id=%0d k=%0d st=%h drop=%b want all 0",
               o_evt_valid, o_evt_id, o_evt_kind, o_state, o_drop);
    end
    step(2);
    n_cmp++;
    if (o_evt_valid !== 1'b0 || o_state !== '0) begin
      n_fail++;
      $display("FAIL reset_held got v=%b st=%h want 0", o_evt_valid, o_state);
    end
    i_rst = 1'b0;
    step(1);
  endtask

  task automatic test_short_press;
    int c_set;
    int cyc_arr[8];
    int k;
    logic [W-1:0] got, want;
    i_evt_ready = 1'b1;
    i_btn = 4'b0001;
    c_set = cyc;
    exp_q.push_back(mk(PRESS, 0));
    exp_q.push_back(mk(IDLE, 0));
    step(3);
    i_btn = '0;
    step(10);
    k = 0;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL short_press missing event want %h", want);
      end else begin
        got = obs_q.pop_front();
        cyc_arr[k] = obs_cyc_q.pop_front();
        if (got !== want) begin
          n_fail++;
          $display("FAIL short_press evt%0d got %h want %h", k, got, want);
        end
      end
      k++;
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL short_press extra events got %0d want 0", obs_q.size());
    end
    obs_q.delete(); obs_cyc_q.delete();
    n_cmp++;
    if (cyc_arr[0] != c_set + 2) begin
      n_fail++;
      $display("FAIL short_press latency got cyc %0d want %0d", cyc_arr[0], c_set + 2);
    end
  endtask

  task automatic test_hold;
    int cyc_arr[8];
    int k;
    logic [W-1:0] got, want;
    i_evt_ready = 1'b1;
    i_btn = 4'b0100;
    exp_q.push_back(mk(PRESS, 2));
    exp_q.push_back(mk(HOLD, 2));
    exp_q.push_back(mk(IDLE, 2));
    step(1);
    n_cmp++;
    if (o_state[5:4] !== PRESS) begin
      n_fail++; $display("FAIL hold_state_e0 got %0d want %0d", o_state[5:4], PRESS);
    end
    step(7);
    n_cmp++;
    if (o_state[5:4] !== PRESS) begin
      n_fail++; $display("FAIL hold_state_e7 got %0d want %0d", o_state[5:4], PRESS);
    end
    step(1);
    n_cmp++;
    if (o_state[5:4] !== HOLD) begin
      n_fail++; $display("FAIL hold_state_e8 got %0d want %0d", o_state[5:4], HOLD);
    end
    step(3);
    i_btn = '0;
    step(1);
    n_cmp++;
    if (o_state[5:4] !== IDLE) begin
      n_fail++; $display("FAIL hold_state_rel got %0d want %0d", o_state[5:4], IDLE);
    end
    step(10);
    k = 0;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL hold missing event want %h", want);
      end else begin
        got = obs_q.pop_front();
        cyc_arr[k] = obs_cyc_q.pop_front();
        if (got !== want) begin
          n_fail++;
          $display("FAIL hold evt%0d got %h want %h", k, got, want);
        end
      end
      k++;
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL hold extra events got %0d want 0", obs_q.size());
    end
    obs_q.delete(); obs_cyc_q.delete();
    n_cmp++;
    if (cyc_arr[1] - cyc_arr[0] != HOLD_CYC) begin
      n_fail++;
      $display("FAIL hold_delay got %0d want %0d", cyc_arr[1] - cyc_arr[0], HOLD_CYC);
    end
  endtask

  task automatic test_all_same_edge;
    int cyc_arr[8];
    int k;
    logic [W-1:0] got, want;
    i_rst = 1'b1;
    step(1);
    i_rst = 1'b0;
    i_evt_ready = 1'b1;
    i_btn = 4'b1111;
    for (int i = 0; i < NUM_BTN; i++) exp_q.push_back(mk(PRESS, i));
    for (int i = 0; i < NUM_BTN; i++) exp_q.push_back(mk(IDLE, i));
    step(5);
    i_btn = '0;
    step(12);
    k = 0;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL all_same missing event want %h", want);
      end else begin
        got = obs_q.pop_front();
        cyc_arr[k] = obs_cyc_q.pop_front();
        if (got !== want) begin
          n_fail++;
          $display("FAIL all_same evt%0d got %h want %h", k, got, want);
        end
      end
      k++;
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL all_same extra events got %0d want 0", obs_q.size());
    end
    obs_q.delete(); obs_cyc_q.delete();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (cyc_arr[i+1] - cyc_arr[i] != 1 || cyc_arr[i+5] - cyc_arr[i+4] != 1) begin
        n_fail++;
        $display("FAIL all_same_gap%0d got %0d/%0d want 1/1", i,
                 cyc_arr[i+1] - cyc_arr[i], cyc_arr[i+5] - cyc_arr[i+4]);
      end
    end
  endtask

  task automatic test_backpressure;
    int d0;
    int k;
    logic [W-1:0] got, want;
    d0 = drop_cnt;
    i_evt_ready = 1'b0;
    i_btn = 4'b0001;
    exp_q.push_back(mk(PRESS, 0));
    exp_q.push_back(mk(IDLE, 1));
    exp_q.push_back(mk(IDLE, 0));
    step(2);
    i_btn = 4'b0010;
    step(2);
    i_btn = '0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      n_cmp++;
      if (o_evt_valid !== 1'b1 || o_evt_id !== IDW'(0) || o_evt_kind !== PRESS) begin
        n_fail++;
        $display("FAIL bp_stable cyc%0d got v=%b id=%0d k=%0d want v=1 id=0 k=1",
                 i, o_evt_valid, o_evt_id, o_evt_kind);
      end
    end
    n_cmp++;
    if (drop_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL bp_drop got %0d pulses want 1", drop_cnt - d0);
    end
    i_evt_ready = 1'b1;
    step(10);
    k = 0;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL bp missing event want %h", want);
      end else begin
        got = obs_q.pop_front();
        void'(obs_cyc_q.pop_front());
        if (got !== want) begin
          n_fail++;
          $display("FAIL bp evt%0d got %h want %h", k, got, want);
        end
      end
      k++;
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp extra events got %0d want 0", obs_q.size());
    end
    obs_q.delete(); obs_cyc_q.delete();
  endtask

  task automatic test_back_to_back;
    logic pv, prdy;
    logic [IDW-1:0] pid;
    logic [1:0] pk;
    int k;
    logic [W-1:0] got, want;
    exp_q.push_back(mk(PRESS, 3));
    exp_q.push_back(mk(IDLE, 3));
    for (int i = 0; i < 24; i++) begin
      if (i == 0) i_btn = 4'b1000;
      if (i == 3) i_btn = '0;
      i_evt_ready = 1'($urandom_range(0, 1));
      pv = o_evt_valid; pid = o_evt_id; pk = o_evt_kind; prdy = i_evt_ready;
      step(1);
      if (pv && !prdy) begin
        n_cmp++;
        if (o_evt_valid !== 1'b1 || o_evt_id !== pid || o_evt_kind !== pk) begin
          n_fail++;
          $display("FAIL b2b_hold cyc%0d got v=%b id=%0d k=%0d want v=1 id=%0d k=%0d",
                   i, o_evt_valid, o_evt_id, o_evt_kind, pid, pk);
        end
      end
    end
    i_evt_ready = 1'b1;
    step(8);
    k = 0;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL b2b missing event want %h", want);
      end else begin
        got = obs_q.pop_front();
        void'(obs_cyc_q.pop_front());
        if (got !== want) begin
          n_fail++;
          $display("FAIL b2b evt%0d got %h want %h", k, got, want);
        end
      end
      k++;
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b extra events got %0d want 0", obs_q.size());
    end
    obs_q.delete(); obs_cyc_q.delete();
  endtask

  task automatic test_reset_mid;
    int k;
    logic [W-1:0] got, want;
    i_evt_ready = 1'b0;
    i_btn = 4'b0100;
    step(10);
    n_cmp++;
    if (o_evt_valid !== 1'b1 || o_state[5:4] !== HOLD) begin
      n_fail++;
      $display("FAIL rmid_pre got v=%b st=%0d want v=1 st=%0d", o_evt_valid, o_state[5:4], HOLD);
    end
    #2;
    i_rst = 1'b1;
    #1;
    n_cmp++;
    if (o_evt_valid !== 1'b0 || o_evt_id !== '0 || o_evt_kind !== 2'b00 ||
        o_state !== '0 || o_drop !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_async got v=%b id=%0d k=%0d st=%h drop=%b want all 0",
               o_evt_valid, o_evt_id, o_evt_kind, o_state, o_drop);
    end
    step(1);
    #2;
    i_rst = 1'b0;
    i_evt_ready = 1'b1;
    exp_q.push_back(mk(PRESS, 2));
    exp_q.push_back(mk(IDLE, 2));
    step(1);
    n_cmp++;
    if (o_state[5:4] !== PRESS) begin
      n_fail++;
      $display("FAIL rmid_repress got %0d want %0d", o_state[5:4], PRESS);
    end
    step(2);
    i_btn = '0;
    step(10);
    k = 0;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL rmid missing event want %h", want);
      end else begin
        got = obs_q.pop_front();
        void'(obs_cyc_q.pop_front());
        if (got !== want) begin
          n_fail++;
          $display("FAIL rmid evt%0d got %h want %h", k, got, want);
        end
      end
      k++;
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL rmid extra events got %0d want 0", obs_q.size());
    end
    obs_q.delete(); obs_cyc_q.delete();
  endtask

  task automatic test_repeat;
    int cyc_arr[8];
    int k;
    int n_hold;
    logic [W-1:0] got, want;
    i_evt_ready = 1'b1;
    i_btn = 4'b0010;
`ifdef BTN_AUTO_REPEAT_EN
    n_hold = 3;
`else
    n_hold = 1;
`endif
    exp_q.push_back(mk(PRESS, 1));
    for (int i = 0; i < n_hold; i++) exp_q.push_back(mk(HOLD, 1));
    exp_q.push_back(mk(IDLE, 1));
    step(20);
    i_btn = '0;
    step(10);
    k = 0;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL repeat missing event want %h", want);
      end else begin
        got = obs_q.pop_front();
        cyc_arr[k] = obs_cyc_q.pop_front();
        if (got !== want) begin
          n_fail++;
          $display("FAIL repeat evt%0d got %h want %h", k, got, want);
        end
      end
      k++;
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL repeat extra events got %0d want 0", obs_q.size());
    end
    obs_q.delete(); obs_cyc_q.delete();
    n_cmp++;
    if (cyc_arr[1] - cyc_arr[0] != HOLD_CYC) begin
      n_fail++;
      $display("FAIL repeat_first got %0d want %0d", cyc_arr[1] - cyc_arr[0], HOLD_CYC);
    end
    for (int i = 2; i <= n_hold; i++) begin
      n_cmp++;
      if (cyc_arr[i] - cyc_arr[i-1] != REPEAT_CYC) begin
        n_fail++;
        $display("FAIL repeat_gap%0d got %0d want %0d", i, cyc_arr[i] - cyc_arr[i-1], REPEAT_CYC);
      end
    end
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_hold();
    test_all_same_edge();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_repeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_evt_arbiter.md
BTN_EVT_ARBITER -- requirements
Module: btn_evt_arbiter

Interface
REQ-001 SHALL have parameter NUM_BTN, default 4, number of button channels (2..8).
REQ-002 SHALL have parameter HOLD_CYC, default 8, held cycles in PRESS before HOLD (>=2).
REQ-003 SHALL have parameter REPEAT_CYC, default 4, HOLD re-emit period (used only with REQ-030).
REQ-004 SHALL have port i_clk  input  1  single clock, rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port i_btn  input  NUM_BTN  synchronized, debounced button levels, 1 = pressed.
REQ-007 SHALL have port o_evt_valid  output  1  event available.
REQ-008 SHALL have port i_evt_ready  input  1  consumer accepts the event when high with o_evt_valid.
REQ-009 SHALL have port o_evt_id  output  clog2(NUM_BTN)  channel index of the event.
REQ-010 SHALL have port o_evt_kind  output  2  my_pkg::state_e: PRESS = press, HOLD = hold, IDLE = release.
REQ-011 SHALL have port o_state  output  2*NUM_BTN  per-channel state_e; channel n at bits [2n+1:2n].
REQ-012 SHALL have port o_drop  output  1  one-cycle pulse when a pending event is overwritten.

Function
REQ-013 SHALL run one FSM per channel with states IDLE, PRESS, HOLD from my_pkg::state_e.
REQ-014 SHALL move IDLE->PRESS on an edge sampling i_btn[n]=1, clear the hold counter, and raise a PRESS event.
REQ-015 SHALL increment the hold counter on each edge in PRESS with i_btn[n]=1, and move PRESS->HOLD with a HOLD event on the edge where the counter reaches HOLD_CYC-1 (HOLD_CYC cycles after PRESS entry).
REQ-016 SHALL move PRESS->IDLE or HOLD->IDLE on an edge sampling i_btn[n]=0 and raise a release event (kind IDLE).
REQ-017 SHALL never enter an unlisted state; the encoding 2'b11 returns to IDLE on the next edge with no event.
REQ-018 SHALL store each raised event in a one-deep per-channel pending slot on the same edge as the state change.
REQ-019 SHALL, when an event is raised on a channel whose slot is full and not being granted, overwrite the slot with the new event and pulse o_drop for one cycle.
REQ-020 SHALL keep a newly raised event when a slot is granted and refilled on the same edge.
REQ-021 SHALL choose among pending channels round-robin, starting at the channel after the last granted one (channel 0 after reset).
REQ-022 SHALL register the granted event into the output register when it is empty or being accepted that cycle, giving one event per cycle under continuous ready.
REQ-023 SHALL hold o_evt_valid, o_evt_id and o_evt_kind stable while o_evt_valid=1 and i_evt_ready=0.
REQ-024 SHALL assert o_evt_valid at the earliest on the edge after the edge that raised the event (2-edge input-to-valid latency).
REQ-025 SHALL drive o_evt_id and o_evt_kind to 0 while o_evt_valid=0.

Reset
REQ-026 SHALL, while i_rst=1, asynchronously force all FSMs to IDLE, clear counters, pending slots and the output register, and set the round-robin pointer to 0.
REQ-027 SHALL drive o_evt_valid=0, o_evt_id=0, o_evt_kind=IDLE, o_state=all IDLE and o_drop=0 during reset.
REQ-028 SHALL discard any in-flight or pending events when reset is asserted mid-operation, with no event emitted afterwards for them.
REQ-029 SHALL treat a button held through reset release as a new press: PRESS on the first edge after release.

Configuration
REQ-030 SHALL, when the macro BTN_AUTO_REPEAT_EN is defined, raise an additional HOLD event every REPEAT_CYC edges while a channel stays in HOLD with i_btn[n]=1.
REQ-031 SHALL, without BTN_AUTO_REPEAT_EN, raise exactly one HOLD event per press, include no repeat counter logic, and ignore REPEAT_CYC.

Verification
REQ-032 SHALL cover: ch0 pressed 3 cycles, ready=1 -> PRESS id0, then release id0; no HOLD.
REQ-033 SHALL cover: ch2 held 12 cycles, HOLD_CYC=8 -> PRESS, HOLD 8 cycles after PRESS entry, release; o_state[5:4] follows the FSM.
REQ-034 SHALL cover: ch0..ch3 pressed on the same edge, ready=1 -> PRESS ids 0,1,2,3 on consecutive cycles; next round starts at id0.
REQ-035 SHALL cover: ready=0 for 20 cycles, ch1 press then release -> o_evt_valid stable with id0 event, ch1 slot overwritten with release, o_drop pulses once.
REQ-036 SHALL cover: i_rst asserted mid-HOLD with valid=1 -> outputs reach reset values without waiting for a clock edge; no stale event after release.
REQ-037 SHALL cover: with BTN_AUTO_REPEAT_EN, REPEAT_CYC=4, hold 20 cycles -> HOLD events every 4 cycles after the first; without the macro, a single HOLD.
